// File: rtl/vending_if.sv
// Handshake bundle between a vending front-panel driver and the vending controller.
// The master drives coins/requests; the slave (controller) returns credit and pulses.
interface vending_if #(
    parameter int unsigned N_PROD = 4,
    parameter int unsigned CW     = 8
);
    localparam int unsigned SW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    logic [1:0]    coin;
    logic          vend_req;
    logic [SW-1:0] sel;
    logic          cancel;
    logic [CW-1:0] credit;
    logic          pr;
    logic [SW-1:0] pr_id;
    logic          change;
    logic          busy;
    logic          deny;
    logic          coin_rej;

    modport master (
        output coin, vend_req, sel, cancel,
        input  credit, pr, pr_id, change, busy, deny, coin_rej
    );

    modport slave (
        input  coin, vend_req, sel, cancel,
        output credit, pr, pr_id, change, busy, deny, coin_rej
    );
endinterface

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates credit, dispenses one product per
// accepted request and returns leftover credit as one-unit change pulses.
module vending_ctrl #(
    parameter int unsigned              N_PROD     = 4,
    parameter int unsigned              CW         = 8,
    parameter int unsigned              MAX_CREDIT = 20,
    parameter logic [N_PROD*CW-1:0]     PRICES     = {8'd7, 8'd5, 8'd4, 8'd3},
    parameter int unsigned              V1         = 1,
    parameter int unsigned              V2         = 2,
    parameter int unsigned              V3         = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    vending_if.slave  bus
);
    localparam int unsigned SW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [SW-1:0] pr_id_q, pr_id_d;
    logic          pr_q, pr_d;
    logic          change_q, change_d;
    logic          busy_q, busy_d;
    logic          deny_q, deny_d;
    logic          coin_rej_q, coin_rej_d;

    logic [CW-1:0] coin_val;
    logic [CW-1:0] price;
    logic          sel_valid;
    logic [CW:0]   sum;
    logic          has_coin;
    logic          coin_fits;
    logic          can_vend;

    always_comb begin
        case (bus.coin)
            2'd1:    coin_val = CW'(V1);
            2'd2:    coin_val = CW'(V2);
            2'd3:    coin_val = CW'(V3);
            default: coin_val = '0;
        endcase

        // Out-of-range selections never match, leaving sel_valid low.
        price     = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < int'(N_PROD); i++) begin
            if (bus.sel == SW'(i)) begin
                price     = PRICES[i*CW +: CW];
                sel_valid = 1'b1;
            end
        end

        has_coin  = (bus.coin != 2'd0);
        sum       = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits = (sum <= (CW+1)'(MAX_CREDIT));
        can_vend  = bus.vend_req && sel_valid && (credit_q >= price);
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        pr_id_d    = pr_id_q;
        deny_d     = 1'b0;
        coin_rej_d = 1'b0;

        case (state_q)
            StIdle: begin
                deny_d = bus.vend_req;
                if (has_coin) begin
                    if (coin_fits) begin
                        credit_d = sum[CW-1:0];
                        state_d  = StCollect;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                if (bus.cancel) begin
                    state_d    = StChange;
                    coin_rej_d = has_coin;
                end else if (can_vend) begin
                    pr_id_d    = bus.sel;
                    credit_d   = credit_q - price;
                    state_d    = StVend;
                    coin_rej_d = has_coin;
                end else begin
                    deny_d = bus.vend_req;
                    if (has_coin) begin
                        if (coin_fits) credit_d = sum[CW-1:0];
                        else           coin_rej_d = 1'b1;
                    end
                end
            end
            StVend: begin
                coin_rej_d = has_coin;
                state_d    = (credit_q != '0) ? StChange : StIdle;
            end
            StChange: begin
                coin_rej_d = has_coin;
                // Leave on the edge that empties credit so pulses equal entry credit.
                if (credit_q <= CW'(1)) begin
                    credit_d = '0;
                    state_d  = StIdle;
                end else begin
                    credit_d = credit_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        pr_d     = (state_d == StVend);
        change_d = (state_d == StChange);
        busy_d   = pr_d || change_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            credit_q   <= '0;
            pr_id_q    <= '0;
            pr_q       <= 1'b0;
            change_q   <= 1'b0;
            busy_q     <= 1'b0;
            deny_q     <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            pr_id_q    <= pr_id_d;
            pr_q       <= pr_d;
            change_q   <= change_d;
            busy_q     <= busy_d;
            deny_q     <= deny_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign bus.credit   = credit_q;
    assign bus.pr       = pr_q;
    assign bus.pr_id    = pr_id_q;
    assign bus.change   = change_q;
    assign bus.busy     = busy_q;
    assign bus.deny     = deny_q;
    assign bus.coin_rej = coin_rej_q;
endmodule
